// File: rtl/spike_enc_pkg.sv
// Shared types and LFSR helpers for the spike encoder.
package spike_enc_pkg;

  typedef enum logic [2:0] {LOAD, ENCODE, FIRE, WAIT, DONE} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois taps for the supported generator widths
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = {16'h0000, LFSR_TAPS};
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] taps);
    lfsr_next = (v >> 1) ^ (v[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// Galois LFSR with seed reload and step enable; exposes the low OUT_W bits.
module spike_lfsr
  import spike_enc_pkg::*;
#(
  parameter int             W     = 16,
  parameter int             OUT_W = 8,
  parameter logic [W-1:0]   SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  output logic [OUT_W-1:0] o_rnd
);

  localparam logic [W-1:0]  SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [31:0]   TAPS     = lfsr_taps(W);

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_lfsr <= SEED_EFF;
    else if (i_load) r_lfsr <= SEED_EFF;
    else if (i_step) r_lfsr <= W'(lfsr_next(32'(r_lfsr), TAPS));
  end

  assign o_rnd = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/spike_encoder.sv
// Frame buffer + LFSR rate encoder feeding a spiking layer. Optional double
// buffering of spike trains is enabled with SPK_ENC_DBUF_EN.
//   state  | meaning
//   LOAD   | accept one frame of pixels
//   ENCODE | one pixel per cycle into the spike train
//   FIRE   | one-cycle pre_synp_avail pulse
//   WAIT   | hold train until layer_avail
//   DONE   | one-cycle frame_done pulse
module spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int                       PRE_SYN_LAYER_SIZE = 784,
  parameter int                       TIME_STEPS         = 4,
  parameter int                       PIXEL_WIDTH        = 8,
  parameter int                       LFSR_WIDTH         = 16,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_SEED          = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_valid,
  input  logic [PIXEL_WIDTH-1:0]          pix_data,
  output logic                            pix_ready,
  input  logic                            layer_avail,
  output logic                            pre_synp_avail,
  output logic [PRE_SYN_LAYER_SIZE-1:0]   pre_synpt_spk_train,
  output logic [$clog2(TIME_STEPS)-1:0]   ts_idx,
  output logic                            frame_done
);

  localparam int                CNT_W    = $clog2(PRE_SYN_LAYER_SIZE);
  localparam int                TS_W     = $clog2(TIME_STEPS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRE_SYN_LAYER_SIZE - 1);
  localparam logic [TS_W-1:0]   TS_LAST  = TS_W'(TIME_STEPS - 1);

  state_t                        r_state, w_state_nxt;
  logic [CNT_W-1:0]              r_cnt;
  logic [TS_W-1:0]               r_ts;
  logic                          r_rdy;
  logic [PIXEL_WIDTH-1:0]        r_pix [PRE_SYN_LAYER_SIZE];
  logic [PRE_SYN_LAYER_SIZE-1:0] r_spk;
  logic [PIXEL_WIDTH-1:0]        w_rnd;
  logic                          w_accept, w_spk_bit, w_ts_last, w_cnt_last;
  logic                          w_lfsr_load, w_lfsr_step;

  assign pix_ready           = (r_state == LOAD) && r_rdy;
  assign w_accept            = pix_valid && pix_ready;
  assign w_ts_last           = (r_ts == TS_LAST);
  assign w_cnt_last          = (r_cnt == CNT_LAST);
  assign w_spk_bit           = (r_pix[r_cnt] != '0) && (r_pix[r_cnt] >= w_rnd);
  assign pre_synp_avail      = (r_state == FIRE);
  assign frame_done          = (r_state == DONE);
  assign pre_synpt_spk_train = r_spk;
  assign ts_idx              = r_ts;

`ifdef SPK_ENC_DBUF_EN
  logic [PRE_SYN_LAYER_SIZE-1:0] r_shd;
  logic [CNT_W-1:0]              r_sh_cnt;
  logic                          r_sh_done, r_ack_pend;
  logic                          w_sh_run, w_swap, w_sh_bit;

  // Next step is encoded into the shadow while the layer works on the current one
  assign w_sh_run = (r_state == WAIT) && !w_ts_last && !r_sh_done;
  assign w_swap   = (r_state == WAIT) && !w_ts_last && r_sh_done && (layer_avail || r_ack_pend);
  assign w_sh_bit = (r_pix[r_sh_cnt] != '0) && (r_pix[r_sh_cnt] >= w_rnd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shd      <= '0;
      r_sh_cnt   <= '0;
      r_sh_done  <= 1'b0;
      r_ack_pend <= 1'b0;
    end else if (w_swap) begin
      r_sh_cnt   <= '0;
      r_sh_done  <= 1'b0;
      r_ack_pend <= 1'b0;
    end else begin
      if (w_sh_run) begin
        r_shd[r_sh_cnt] <= w_sh_bit;
        r_sh_cnt        <= (r_sh_cnt == CNT_LAST) ? '0 : r_sh_cnt + 1'b1;
        if (r_sh_cnt == CNT_LAST) r_sh_done <= 1'b1;
      end
      if ((r_state == WAIT) && layer_avail && !w_ts_last && !r_sh_done) r_ack_pend <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept && w_cnt_last) begin
          w_state_nxt = ENCODE;
          w_lfsr_load = 1'b1;
        end
      end
      ENCODE: begin
        w_lfsr_step = 1'b1;
        if (w_cnt_last) w_state_nxt = FIRE;
      end
      FIRE: w_state_nxt = WAIT;
      WAIT: begin
`ifdef SPK_ENC_DBUF_EN
        w_lfsr_step = w_sh_run;
        if (layer_avail && w_ts_last) w_state_nxt = DONE;
        else if (w_swap)              w_state_nxt = FIRE;
`else
        if (layer_avail) w_state_nxt = w_ts_last ? DONE : ENCODE;
`endif
      end
      DONE:    w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_ts    <= '0;
      r_rdy   <= 1'b0;
      r_spk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= 1'b1;
      case (r_state)
        LOAD: begin
          if (w_accept) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        ENCODE: begin
          r_spk[r_cnt] <= w_spk_bit;
          r_cnt        <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        WAIT: begin
`ifdef SPK_ENC_DBUF_EN
          if (w_swap) begin
            r_spk <= r_shd;
            r_ts  <= r_ts + 1'b1;
          end else if (layer_avail && w_ts_last) begin
            r_ts  <= '0;
          end
`else
          if (layer_avail) begin
            r_cnt <= '0;
            r_ts  <= w_ts_last ? '0 : r_ts + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Pixel memory carries no reset; a restarted frame overwrites every entry
  always_ff @(posedge clk) begin
    if (w_accept) r_pix[r_cnt] <= pix_data;
  end

  spike_lfsr #(
    .W     (LFSR_WIDTH),
    .OUT_W (PIXEL_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_lfsr_load),
    .i_step (w_lfsr_step),
    .o_rnd  (w_rnd)
  );

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench for spike_encoder (default build, 784 pixels, 4 steps).
module tb_spike_encoder;

  localparam int N = 784;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = '0;
  logic         pix_ready;
  logic         layer_avail = 1'b0;
  logic         pre_synp_avail;
  logic [N-1:0] train;
  logic [1:0]   ts_idx;
  logic         frame_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] v_zero, v_ones, v_c;
  logic [3:0]   mbit;

  spike_encoder dut (
    .clk                 (clk),
    .rst                 (rst),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .pix_ready           (pix_ready),
    .layer_avail         (layer_avail),
    .pre_synp_avail      (pre_synp_avail),
    .pre_synpt_spk_train (train),
    .ts_idx              (ts_idx),
    .frame_done          (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: all zero, 1: all 255, 2: pixel 0 = 128 rest 0
  task automatic load(input int mode, input bit toggle);
    int acc = 0;
    int cyc = 0;
    while (acc < N && cyc < 4000) begin
      pix_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (!pix_valid)     pix_data = 8'hFF;
      else if (mode == 0) pix_data = 8'h00;
      else if (mode == 1) pix_data = 8'hFF;
      else                pix_data = (acc == 0) ? 8'd128 : 8'd0;
      if (pix_valid && pix_ready) acc++;
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    pix_data  = '0;
    chk("accepted", acc, N);
    chk("rdy_encode", pix_ready, 0);
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    while (pre_synp_avail !== 1'b1 && lat < 3000) begin
      tick();
      lat++;
    end
  endtask

  task automatic step(input int k, input logic [N-1:0] exp);
    int lat;
    wait_pulse(lat);
    chk($sformatf("lat_s%0d", k), lat, N);
    chk($sformatf("ts_s%0d", k), ts_idx, k);
    chkv($sformatf("train_s%0d", k), train, exp);
    tick();
    chk($sformatf("pulse1_s%0d", k), pre_synp_avail, 0);
    chk($sformatf("rdy_wait_s%0d", k), pix_ready, 0);
    repeat (4) tick();
    chkv($sformatf("hold_s%0d", k), train, exp);
    layer_avail = 1'b1;
    tick();
    layer_avail = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_fd"}, frame_done, 1);
    chk({tag, "_ts0"}, ts_idx, 0);
    chk({tag, "_rdy_done"}, pix_ready, 0);
    tick();
    chk({tag, "_fd_off"}, frame_done, 0);
    chk({tag, "_rdy_load"}, pix_ready, 1);
  endtask

  initial begin
    int lat;
    int extra;
    logic [15:0] l;

    v_zero = '0;
    v_ones = '1;
    l = 16'hACE1;
    for (int k = 0; k < 4; k++) begin
      mbit[k] = (8'd128 >= l[7:0]);
      for (int i = 0; i < N; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end

    repeat (3) tick();
    chk("rst_rdy", pix_ready, 0);
    chk("rst_avail", pre_synp_avail, 0);
    chk("rst_ts", ts_idx, 0);
    chk("rst_fd", frame_done, 0);
    chkv("rst_train", train, v_zero);
    rst = 1'b1;
    chk("rel_rdy0", pix_ready, 0);
    tick();
    chk("rel_rdy1", pix_ready, 1);

    // Frame A: zeros, pix_valid toggling; invalid cycles carry 0xFF
    load(0, 1'b1);
    for (int k = 0; k < 4; k++) step(k, v_zero);
    check_done("A");

    // Frame B: all 255, reset while waiting in step 2
    load(1, 1'b0);
    step(0, v_ones);
    step(1, v_ones);
    wait_pulse(lat);
    chk("lat_B2", lat, N);
    chk("ts_B2", ts_idx, 2);
    chkv("train_B2", train, v_ones);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_avail", pre_synp_avail, 0);
    chkv("mid_rst_train", train, v_zero);
    chk("mid_rst_ts", ts_idx, 0);
    chk("mid_rst_rdy", pix_ready, 0);
    chk("mid_rst_fd", frame_done, 0);
    tick();
    rst = 1'b1;
    chk("mid_rel_rdy0", pix_ready, 0);
    tick();
    chk("mid_rel_rdy1", pix_ready, 1);

    // Frame C: pixel 0 = 128; stray layer_avail in ENCODE and FIRE
    load(2, 1'b0);
    layer_avail = 1'b1;
    tick();
    layer_avail = 1'b0;
    wait_pulse(lat);
    chk("lat_C0", lat + 1, N);
    chk("ts_C0", ts_idx, 0);
    v_c = '0; v_c[0] = mbit[0];
    chkv("train_C0", train, v_c);
    layer_avail = 1'b1;
    tick();
    layer_avail = 1'b0;
    chk("fire_ack_avail", pre_synp_avail, 0);
    chk("fire_ack_ts", ts_idx, 0);
    extra = 0;
    repeat (900) begin
      if (pre_synp_avail) extra++;
      tick();
    end
    chk("no_extra_pulse", extra, 0);
    chk("still_ts0", ts_idx, 0);
    chkv("still_train_C0", train, v_c);
    layer_avail = 1'b1;
    tick();
    layer_avail = 1'b0;
    for (int k = 1; k < 4; k++) begin
      v_c = '0; v_c[0] = mbit[k];
      step(k, v_c);
    end
    check_done("C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
